memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_pkg.sv | 54 +++++
 rtl/memory_access_load_align.sv | 41 ++++
 rtl/memory_access.sv | 133 +++++++++++++
 3 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg
//   Constants shared by the CPU memory stage: LSU access sizes, data bus
//   command codes and the memory-stage state encoding, plus small helpers
//   for alignment checking, byte-enable generation and store lane
//   replication.
package memory_access_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_BYTE  = 2'd1,
        LSU_HWORD = 2'd2,
        LSU_WORD  = 2'd3
    } lsu_op_e;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_READ  = 2'd1,
        BUS_WRITE = 2'd2
    } bus_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] addr_lo);
        case (op)
            LSU_HWORD: return addr_lo[0];
            LSU_WORD:  return |addr_lo;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input lsu_op_e op, input logic [1:0] addr_lo);
        case (op)
            LSU_BYTE:  return 4'b0001 << addr_lo;
            LSU_HWORD: return addr_lo[1] ? 4'b1100 : 4'b0011;
            LSU_WORD:  return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Narrow store data is copied into every lane so the slave only needs
    // to honour the byte enables.
    function automatic logic [31:0] store_lanes(input lsu_op_e op, input logic [31:0] data);
        case (op)
            LSU_BYTE:  return {4{data[7:0]}};
            LSU_HWORD: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// lsu_load_align
//   Combinational load-data aligner: selects the byte or halfword lane
//   addressed by addr[1:0] from a 32-bit bus word and sign- or zero-extends
//   it to 32 bits.
//   Ports:
//     addr   in  2   low address bits selecting the lane
//     size   in  2   access size (lsu_op_e)
//     ext    in  1   1 = sign-extend, 0 = zero-extend
//     word   in  32  raw bus read data
//     value  out 32  aligned, extended result
module lsu_load_align
    import memory_access_pkg::*;
(
    input  logic [1:0]  addr,
    input  lsu_op_e     size,
    input  logic        ext,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase

        lane_h = addr[1] ? word[31:16] : word[15:0];

        case (size)
            LSU_BYTE:  value = {{24{ext & lane_b[7]}}, lane_b};
            LSU_HWORD: value = {{16{ext & lane_h[15]}}, lane_h};
            default:   value = word;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// memory_access
//   CPU memory stage. Passes non-memory results straight to writeback,
//   flags misaligned accesses, and runs loads/stores over a simple
//   command/ack + ready data bus. Stores are posted (finish on command
//   ack); loads wait for read data and write back the extended value.
//   Ports:
//     clk, nrst                 clock, synchronous active-low reset
//     i_fetch_stall             hold off accepting a new instruction
//     o_mem_stall               stage busy with a bus transaction
//     i_rd_no, i_alu_result     destination register, ALU result / address
//     i_lsu_op, i_lsu_lns,
//     i_lsu_ext, i_mem_data     access size, load/store, sign-ext, store data
//     o_dbus_addr/cmd/be/data   data bus request
//     i_dbus_cmd_ack            bus accepted the request
//     i_dbus_rdy, i_dbus_data   read data valid, read data
//     o_rd_no, o_rd_val         writeback register and value
//     o_addr_err                one-cycle misaligned-access pulse
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_fetch_stall,
    output logic                  o_mem_stall,
    input  logic [4:0]            i_rd_no,
    input  logic [31:0]           i_alu_result,
    input  logic [1:0]            i_lsu_op,
    input  logic                  i_lsu_lns,
    input  logic                  i_lsu_ext,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [ADDR_WIDTH-1:0] o_dbus_addr,
    output logic [1:0]            o_dbus_cmd,
    output logic [3:0]            o_dbus_be,
    output logic [DATA_WIDTH-1:0] o_dbus_data,
    input  logic                  i_dbus_cmd_ack,
    input  logic                  i_dbus_rdy,
    input  logic [DATA_WIDTH-1:0] i_dbus_data,
    output logic [4:0]            o_rd_no,
    output logic [31:0]           o_rd_val,
    output logic                  o_addr_err
);

    mem_state_e  state;
    lsu_op_e     op_in;
    lsu_op_e     lat_size;
    logic [1:0]  lat_addr_lo;
    logic        lat_lns;
    logic        lat_ext;
    logic [4:0]  lat_rd_no;
    logic [31:0] load_value;

    assign op_in       = lsu_op_e'(i_lsu_op);
    assign o_mem_stall = (state != ST_IDLE);

    lsu_load_align u_load_align (
        .addr  (lat_addr_lo),
        .size  (lat_size),
        .ext   (lat_ext),
        .word  (i_dbus_data),
        .value (load_value)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= ST_IDLE;
            lat_size    <= LSU_IDLE;
            lat_addr_lo <= '0;
            lat_lns     <= 1'b0;
            lat_ext     <= 1'b0;
            lat_rd_no   <= '0;
            o_dbus_addr <= '0;
            o_dbus_cmd  <= BUS_IDLE;
            o_dbus_be   <= '0;
            o_dbus_data <= '0;
            o_rd_no     <= '0;
            o_rd_val    <= '0;
            o_addr_err  <= 1'b0;
        end else begin
            // The error flag is a pulse; it never survives a held stall.
            o_addr_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!i_fetch_stall) begin
                        if (op_in == LSU_IDLE) begin
                            o_rd_no  <= i_rd_no;
                            o_rd_val <= i_alu_result;
                        end else if (is_misaligned(op_in, i_alu_result[1:0])) begin
                            o_rd_no    <= '0;
                            o_addr_err <= 1'b1;
                        end else begin
                            lat_size    <= op_in;
                            lat_addr_lo <= i_alu_result[1:0];
                            lat_lns     <= i_lsu_lns;
                            lat_ext     <= i_lsu_ext;
                            lat_rd_no   <= i_rd_no;
                            o_dbus_addr <= {i_alu_result[ADDR_WIDTH-1:2], 2'b00};
                            o_dbus_cmd  <= i_lsu_lns ? BUS_READ : BUS_WRITE;
                            o_dbus_be   <= byte_enables(op_in, i_alu_result[1:0]);
                            o_dbus_data <= store_lanes(op_in, i_mem_data);
                            o_rd_no     <= '0;
                            state       <= ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    o_rd_no <= '0;
                    if (i_dbus_cmd_ack) begin
                        o_dbus_cmd <= BUS_IDLE;
                        state      <= lat_lns ? ST_WAIT : ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (i_dbus_rdy) begin
                        o_rd_val <= load_value;
                        o_rd_no  <= lat_rd_no;
                        state    <= ST_IDLE;
                    end else begin
                        o_rd_no <= '0;
                    end
                end
                default: begin
                    o_dbus_cmd <= BUS_IDLE;
                    o_rd_no    <= '0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
